// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: grant, operand capture,
// one-cycle execute, held response. Define ALU_SHARE_FIXED_PRIO_EN for fixed priority to requester 0.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  input  logic [OPW-1:0]   req_op_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  output logic             req_ready_0,
  input  logic             req_valid_1,
  input  logic [OPW-1:0]   req_op_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  output logic             req_ready_1,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  input  logic             resp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_resp_id;
  logic             r_resp_valid;
  logic             r_busy;
  logic             r_last_grant;

  logic             w_grant_0;
  logic             w_grant_1;
  logic             w_idle;
  logic             w_acc_0;
  logic             w_acc_1;

  // Arbitration: a tie goes to the requester that did not win last time
  always_comb begin
    w_grant_0 = 1'b0;
    w_grant_1 = 1'b0;
    if (req_valid_0 && req_valid_1) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      w_grant_0 = 1'b1;
      w_grant_1 = 1'b0;
`else
      w_grant_0 = r_last_grant;
      w_grant_1 = ~r_last_grant;
`endif
    end else if (req_valid_0) begin
      w_grant_0 = 1'b1;
    end else if (req_valid_1) begin
      w_grant_1 = 1'b1;
    end else begin
      w_grant_0 = 1'b0;
      w_grant_1 = 1'b0;
    end
  end

  assign w_idle      = (r_state == S_IDLE);
  assign w_acc_0     = w_idle & w_grant_0 & req_valid_0;
  assign w_acc_1     = w_idle & w_grant_1 & req_valid_1;
  assign req_ready_0 = w_acc_0;
  assign req_ready_1 = w_acc_1;

  // ALU is driven only from the captured operands, so it sees stable inputs in EXEC
  assign alu_in1    = r_a;
  assign alu_in2    = r_b;
  assign alu_op     = r_op;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = r_busy;

  // Control FSM with operand capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_resp_data  <= '0;
      r_resp_id    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc_0 || w_acc_1) begin
            r_a          <= w_acc_1 ? req_a_1  : req_a_0;
            r_b          <= w_acc_1 ? req_b_1  : req_b_0;
            r_op         <= w_acc_1 ? req_op_1 : req_op_0;
            r_resp_id    <= w_acc_1;
            r_last_grant <= w_acc_1;
            r_busy       <= 1'b1;
            r_state      <= S_EXEC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_resp_data  <= alu_out;
          r_resp_valid <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (accept cycle, expected result, response order).
module tb_alu_share_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid_0, req_valid_1;
  logic [OPW-1:0]   req_op_0, req_op_1;
  logic [WIDTH-1:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic             req_ready_0, req_ready_1;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
  logic [OPW-1:0]   alu_op;
  logic             resp_valid, resp_id, resp_ready, busy;
  logic [WIDTH-1:0] resp_data;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_op_0(req_op_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
    .req_ready_0(req_ready_0),
    .req_valid_1(req_valid_1), .req_op_1(req_op_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
    .req_ready_1(req_ready_1),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy)
  );

  function automatic logic [WIDTH-1:0] alu_ref(input logic [OPW-1:0] op,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      8'd0:    return a + b;
      8'd1:    return a - b;
      8'd2:    return a | b;
      8'd3:    return (b >= 32'd32) ? 32'd0 : (a << b);
      8'd4:    return (a == b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // The shared ALU itself lives in the bench
  assign alu_out = alu_ref(alu_op, alu_in1, alu_in2);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model state
  int               cyc = 0;
  bit               m_out = 1'b0;
  int               m_acc_cyc = 0;
  bit               m_last = 1'b1;
  bit               m_id;
  logic [WIDTH-1:0] m_data, m_a, m_b;
  logic [OPW-1:0]   m_op;
  bit               acc_0, acc_1;
  int               id_log[$];
  int               acc_log[$];

  function automatic int exp_grant(input bit v0, input bit v1, input bit last);
`ifdef ALU_SHARE_FIXED_PRIO_EN
    if (v0) return 0;
    if (v1) return 1;
    return -1;
`else
    if (v0 && v1) return (last == 1'b0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
`endif
  endfunction

  // One clock: check at the falling edge, update the model, return 1ns after the rising edge
  task automatic step();
    int g;
    bit rv_exp;
    acc_0 = 1'b0;
    acc_1 = 1'b0;
    @(negedge clk);
    g = m_out ? -1 : exp_grant(req_valid_0, req_valid_1, m_last);
    rv_exp = m_out && (cyc >= m_acc_cyc + 2);
    check_eq("ready0", req_ready_0, g == 0);
    check_eq("ready1", req_ready_1, g == 1);
    check_eq("busy", busy, m_out);
    check_eq("resp_valid", resp_valid, rv_exp);
    if (m_out) begin
      check_eq("alu_in1", alu_in1, m_a);
      check_eq("alu_in2", alu_in2, m_b);
      check_eq("alu_op", alu_op, m_op);
    end
    if (rv_exp) begin
      check_eq("resp_data", resp_data, m_data);
      check_eq("resp_id", resp_id, m_id);
      if (resp_ready) begin
        m_out = 1'b0;
        id_log.push_back(int'(m_id));
      end
    end else if (!m_out && g >= 0) begin
      m_out     = 1'b1;
      m_acc_cyc = cyc;
      m_id      = (g == 1);
      m_a       = (g == 1) ? req_a_1 : req_a_0;
      m_b       = (g == 1) ? req_b_1 : req_b_0;
      m_op      = (g == 1) ? req_op_1 : req_op_0;
      m_data    = alu_ref(m_op, m_a, m_b);
      m_last    = (g == 1);
      acc_0     = (g == 0);
      acc_1     = (g == 1);
      acc_log.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    resp_ready  = 1'b1;
    for (int k = 0; k < 10 && m_out; k++) step();
    check_eq("drain_idle", busy, 1'b0);
  endtask

  task automatic one_op(input string tag, input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    bit got;
    got = 1'b0;
    resp_ready  = 1'b1;
    req_valid_0 = 1'b1;
    req_op_0 = op; req_a_0 = a; req_b_0 = b;
    for (int k = 0; k < 8; k++) begin
      step();
      if (acc_0) begin
        got = 1'b1;
        break;
      end
    end
    check_eq({tag, "_acc"}, got, 1'b1);
    req_valid_0 = 1'b0;
    for (int k = 0; k < 4 && !resp_valid; k++) step();
    check_eq({tag, "_valid"}, resp_valid, 1'b1);
    check_eq(tag, resp_data, exp);
    drain();
  endtask

  task automatic rand_req(output logic [OPW-1:0] op, output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b);
    if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(5, 255));
    else op = 8'($urandom_range(0, 4));
    a = $urandom;
    b = $urandom;
    if (op == 8'd3 && $urandom_range(0, 3) != 0) b = 32'($urandom_range(0, 40));
    if (op == 8'd4 && $urandom_range(0, 1) == 0) b = a;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_0 = 1'b0; req_op_0 = '0; req_a_0 = '0; req_b_0 = '0;
    req_valid_1 = 1'b0; req_op_1 = '0; req_a_1 = '0; req_b_1 = '0;
    resp_ready = 1'b0;
    #12;
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_resp_data", resp_data, 32'd0);
    check_eq("rst_resp_id", resp_id, 1'b0);
    check_eq("rst_alu_in1", alu_in1, 32'd0);
    check_eq("rst_alu_op", alu_op, 8'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Both requesters valid continuously
    req_valid_0 = 1'b1; req_op_0 = 8'd1; req_a_0 = 32'd10;   req_b_0 = 32'd3;
    req_valid_1 = 1'b1; req_op_1 = 8'd2; req_a_1 = 32'hF0;   req_b_1 = 32'h0F;
    resp_ready = 1'b1;
    id_log.delete();
    acc_log.delete();
    for (int k = 0; k < 12; k++) step();
    check_eq("alt_count", id_log.size(), 32'd4);
    for (int k = 0; k < id_log.size(); k++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      check_eq("fixed_id", id_log[k], 32'd0);
`else
      check_eq("alt_id", id_log[k], k % 2);
`endif
    end
    for (int k = 1; k < acc_log.size(); k++) check_eq("acc_spacing", acc_log[k] - acc_log[k-1], 32'd3);
    drain();

    // Single request with explicit latency
    req_valid_0 = 1'b1; req_op_0 = 8'd0; req_a_0 = 32'd5; req_b_0 = 32'd7;
    step();
    check_eq("t1_acc", acc_0, 1'b1);
    req_valid_0 = 1'b0;
    check_eq("t1_busy_exec", busy, 1'b1);
    check_eq("t1_nvalid_exec", resp_valid, 1'b0);
    step();
    check_eq("t1_valid", resp_valid, 1'b1);
    check_eq("t1_data", resp_data, 32'd12);
    check_eq("t1_id", resp_id, 1'b0);
    check_eq("t1_busy_done", busy, 1'b1);
    drain();

    // Backpressure with requester 1 waiting
    resp_ready = 1'b0;
    req_valid_0 = 1'b1; req_op_0 = 8'd3; req_a_0 = 32'd1; req_b_0 = 32'd4;
    step();
    check_eq("bp_acc", acc_0, 1'b1);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b1; req_op_1 = 8'd0; req_a_1 = 32'd2; req_b_1 = 32'd2;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("bp_valid", resp_valid, 1'b1);
      check_eq("bp_data", resp_data, 32'd16);
      check_eq("bp_ready1", req_ready_1, 1'b0);
    end
    resp_ready = 1'b1;
    step();
    check_eq("bp_ready1_after", req_ready_1, 1'b1);
    step();
    check_eq("bp_acc1", acc_1, 1'b1);
    drain();

    // Boundaries
    one_op("b_add_wrap", 8'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    one_op("b_sll_32", 8'd3, 32'd1, 32'd32, 32'd0);
    one_op("b_eq", 8'd4, 32'h1234, 32'h1234, 32'd1);
    one_op("b_op9", 8'd9, 32'd77, 32'd5, 32'd0);

    // Reset in the middle of an operation
    req_valid_0 = 1'b1; req_op_0 = 8'd0; req_a_0 = 32'd3; req_b_0 = 32'd4;
    step();
    req_valid_0 = 1'b0;
    check_eq("mr_in_exec", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_resp_valid", resp_valid, 1'b0);
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_resp_data", resp_data, 32'd0);
    check_eq("mr_resp_id", resp_id, 1'b0);
    check_eq("mr_alu_in1", alu_in1, 32'd0);
    check_eq("mr_alu_in2", alu_in2, 32'd0);
    check_eq("mr_alu_op", alu_op, 8'd0);
    m_out  = 1'b0;
    m_last = 1'b1;
    req_valid_0 = 1'b1; req_op_0 = 8'd1; req_a_0 = 32'd9; req_b_0 = 32'd4;
    req_valid_1 = 1'b1; req_op_1 = 8'd2; req_a_1 = 32'd1; req_b_1 = 32'd2;
    rst_n = 1'b1;
    step();
    check_eq("mr_tie_r0", acc_0, 1'b1);
    drain();

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      resp_ready = ($urandom_range(0, 2) != 0);
      step();
      if (acc_0 || (req_valid_0 && $urandom_range(0, 7) == 0)) req_valid_0 = 1'b0;
      else if (!req_valid_0 && $urandom_range(0, 2) == 0) begin
        rand_req(req_op_0, req_a_0, req_b_0);
        req_valid_0 = 1'b1;
      end
      if (acc_1 || (req_valid_1 && $urandom_range(0, 7) == 0)) req_valid_1 = 1'b0;
      else if (!req_valid_1 && $urandom_range(0, 2) == 0) begin
        rand_req(req_op_1, req_a_1, req_b_1);
        req_valid_1 = 1'b1;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU datapath (ops: add, sub, or, shift-left-logical, equal) between two requesters.
- Requester 0 is the main pipeline; requester 1 is an auxiliary unit such as a debug or address-generation helper.
- Round-robin grant, operand capture, one-cycle ALU execution, and a registered result with valid/ready response handshake.
- Sits between the requesters and the ALU instance; the ALU ports are driven only from this block's registers.

Parameters:
- WIDTH, 32, data width of operands and result.
- OPW, 8, ALU opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_0  input  1  requester 0 has an operation pending.
- req_op_0  input  OPW  requester 0 opcode.
- req_a_0  input  WIDTH  requester 0 operand 1.
- req_b_0  input  WIDTH  requester 0 operand 2.
- req_ready_0  output  1  requester 0 accepted this cycle.
- req_valid_1, req_op_1, req_a_1, req_b_1, req_ready_1  same as requester 0, for requester 1.
- alu_in1  output  WIDTH  to ALU Input1.
- alu_in2  output  WIDTH  to ALU Input2.
- alu_op  output  OPW  to ALU ALUOp.
- alu_out  input  WIDTH  from ALU Output.
- resp_valid  output  1  result available.
- resp_id  output  1  index of the requester that owns the result.
- resp_data  output  WIDTH  registered ALU result.
- resp_ready  input  1  consumer takes the result.
- busy  output  1  high when the FSM is not IDLE.

Behaviour:
- Clocking: one clock. rst_n is asynchronous assert, synchronous deassert (deassert is synchronised externally).
- Reset values:
  - State = IDLE.
  - Operand registers, op register, resp_data, resp_id = 0.
  - resp_valid = 0, busy = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Grant is combinational from req_valid_0/1 and last_grant.
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the requester that is not last_grant.
  - req_ready_i = (state==IDLE) && granted==i && req_valid_i. At most one ready is high per cycle.
  - On valid&ready: latch op/a/b into the operand registers, latch resp_id = i, update last_grant = i, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_in1/alu_in2/alu_op are driven from the operand registers at all times, so they are stable throughout EXEC.
  - At the end of the cycle, resp_data <= alu_out, resp_valid <= 1, state -> DONE.
- DONE:
  - resp_valid, resp_id and resp_data are held stable until resp_ready.
  - On resp_valid&resp_ready: resp_valid <= 0, state -> IDLE.
  - The next request can be accepted in the cycle after the handshake; there is no IDLE bypass.
- Latency and throughput:
  - Accept at cycle N gives resp_valid high from N+2.
  - Maximum throughput is one operation per 3 cycles when resp_ready is held high.
- Requester rules:
  - req_valid must not depend on req_ready.
  - Once req_valid is raised, op/a/b are held until accepted.
  - Dropping valid before acceptance is permitted; no grant results.
- Backpressure: while in EXEC or DONE, both req_ready outputs are 0 and pending requests wait.
- Opcodes:
  - 0 add, 1 sub, 2 or, 3 shift-left, 4 equal (result 1 or 0).
  - Any other value is passed through unchanged and the result is whatever the ALU returns, which is 0.
  - The arbiter does no decoding and performs no arithmetic itself.
- Width rules:
  - Add and sub wrap modulo 2^WIDTH.
  - Shift amount is the full operand 2; amounts of WIDTH or more yield 0 (ALU behaviour, passed through).
- busy = (state != IDLE).
- Reset mid-operation: an asserted rst_n=0 in EXEC or DONE discards the operation immediately. resp_valid drops asynchronously, the in-flight result is lost, and last_grant returns to 1.

Optional Feature:
- Macro: ALU_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 0 always wins when both are valid; last_grant is still updated but ignored for arbitration.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset then single request: req_valid_0=1, op=0, a=5, b=7. req_ready_0 is high in the accept cycle; resp_valid=1 two cycles later with resp_data=12 and resp_id=0; busy=1 during EXEC and DONE.
- Both requesters valid continuously (r0: op=1, a=10, b=3; r1: op=2, a=0xF0, b=0x0F), resp_ready=1:
  - Responses alternate id 0 (7), id 1 (0xFF), id 0, id 1.
  - Accepts occur every 3 cycles.
  - With ALU_SHARE_FIXED_PRIO_EN defined, every response is id 0.
- Backpressure: op=3, a=1, b=4 with resp_ready=0 for 5 cycles. resp_data=16 and resp_valid are held stable; a pending req_valid_1 sees req_ready_1=0 until one cycle after resp_ready=1.
- Boundaries:
  - op=0, a=0xFFFFFFFF, b=1 gives 0.
  - op=3, a=1, b=32 gives 0.
  - op=4, a=b=0x1234 gives 1.
  - op=9 gives 0 and resp_valid still asserts.
- Reset mid-operation: assert rst_n=0 during EXEC. All outputs are 0 immediately; after release, a tie grants requester 0 first.
